breath_seq_ctrl: RTL and testbench
==================================

# breath_seq_ctrl

Brightness sequencer for the breathing-LED PWM datapath. It owns the `duty_cycle` and `inc_dec_flag` values consumed by the PWM compare stage. It ramps duty up to a configured ceiling, holds, ramps down to zero, holds, and repeats. All duty updates are aligned to PWM period boundaries so the LED never sees a mid-period glitch. It sits between a host/config source (start/stop/config) and the period counter/comparator.

## Interface
- `DUTY_W`, 16: width of duty, step and ceiling.
- `HOLD_W`, 8: width of the hold count, in PWM periods.
- `DEF_MAX`, 16'd50000: reset value of the duty ceiling.
- `DEF_STEP`, 16'd25: reset value of the duty step.
- `DEF_HOLD`, 8'd0: reset value of the hold count.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: config offer.
- `cfg_ready` out 1: config accepted when `cfg_valid && cfg_ready`.
- `cfg_max` in DUTY_W: duty ceiling.
- `cfg_step` in DUTY_W: duty increment/decrement per period.
- `cfg_hold` in HOLD_W: periods held at top and bottom.
- `start` in 1: one-cycle pulse that starts breathing.
- `stop` in 1: one-cycle pulse for a graceful stop (ramp to 0, then idle).
- `period_end` in 1: one-cycle pulse from the PWM period counter on the last cycle of each period.
- `duty_cycle` out DUTY_W: registered duty to the comparator.
- `inc_dec_flag` out 1: 1 while rising or holding high, 0 otherwise.
- `busy` out 1: state != IDLE.
- `cycle_done` out 1: one-cycle pulse when duty reaches 0 from FALL.

## Operation
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- **Config.** `cfg_ready` = (state == IDLE). On handshake, `cfg_max`/`cfg_step`/`cfg_hold` are registered. `cfg_step` == 0 is stored as 1.
- **IDLE.** `start` → RISE. Duty stays 0. `stop` is ignored.
- **RISE**, on `period_end`: compute sum = duty + step in DUTY_W+1 bits.
  - sum ≥ max: duty = max, load hold_cnt = hold, go to HOLD_HI.
  - Otherwise duty = sum.
- **HOLD_HI**, on `period_end`:
  - hold_cnt != 0: decrement it.
  - hold_cnt == 0: perform the first FALL step and go to FALL.
- **FALL**, on `period_end`:
  - duty ≤ step: duty = 0, pulse `cycle_done`, load hold_cnt, go to HOLD_LO.
  - Otherwise duty -= step.
- **HOLD_LO.** Mirrors HOLD_HI: the counter expires into the first RISE step and goes to RISE.
- Every hold therefore spans exactly `hold` unchanged periods. A hold of 0 means the next period steps immediately.
- **Stop.** `stop` sets stop_pending, cleared on reaching IDLE.
  - RISE/HOLD_HI: the next `period_end` performs a FALL step and goes to FALL, abandoning any remaining hold.
  - FALL: continues to 0, pulses `cycle_done`, then goes to IDLE instead of HOLD_LO.
  - HOLD_LO: go to IDLE on the next clock.
- **Simultaneous events.**
  - `start` and `stop` in the same cycle while IDLE: stop wins, stay IDLE.
  - `start` while busy: ignored.
  - `cfg_valid` with `start` in IDLE: the new config is captured and used for that run.
- **Reset.** Applies mid-operation. On the next edge: state IDLE, duty_cycle 0, inc_dec_flag 0, busy 0, cycle_done 0, stop_pending 0, config regs = DEF_*.

## Timing
- duty_cycle, inc_dec_flag and cycle_done are registered. They change on the clock edge where `period_end` is sampled high, visible the following cycle. Latency is 1 clock from `period_end`.
- `start` → busy = 1 the next cycle. The duty change comes only at the first subsequent `period_end`.
- `period_end` on the same cycle as `start` is not consumed. The first step uses the next `period_end`.
- `period_end` is ignored in IDLE.
- `cfg_ready` drops the cycle after `start` is accepted and rises the cycle after IDLE is re-entered.
- Arithmetic never wraps. Add saturates at max, subtract clamps at 0.

## Structure
- Shared package `breath_pkg` holds:
  - the state enum;
  - DUTY_W/HOLD_W defaults;
  - DEF_MAX/DEF_STEP/DEF_HOLD constants, shared with the PWM datapath and bench.
- Sub-module `breath_step_alu` (combinational) takes duty, step, max and direction. It returns the next duty and a hit_limit flag, using the DUTY_W+1 compare.
- The FSM, hold counter and config registers live in `breath_seq_ctrl`.

## Test plan
- **Ramp and hold.** max=100, step=30, hold=2, start, then `period_end` every 10 clocks.
  - Duty sequence: 30, 60, 90, 100, 100, 100, 70, 40, 10, 0.
  - `cycle_done` pulses on the 0 update.
  - Then 0, 0, 30.
  - inc_dec_flag is 1 through the 100 holds, then 0.
- **Zero hold.** max=100, step=50, hold=0.
  - Duty: 50, 100, 50, 0, 50.
  - HOLD states last one `period_end` each, with the step applied on it.
- **Graceful stop.** Same config as the first scenario; stop while duty=60 in RISE.
  - Next `period_end` gives 30, then 0 with `cycle_done` and IDLE.
  - busy falls the following cycle.
  - Further `period_end` leaves duty 0.
- **Config gating.** cfg_valid while busy → cfg_ready=0, values unchanged. Step=0 at IDLE then start → duty 1, 2, 3….
- **Event races.**
  - start+stop in the same cycle → stays IDLE.
  - start coinciding with `period_end` → no duty change until the next `period_end`.
- **Reset mid-operation.** sys_rst asserted during FALL at duty=40 → next cycle duty 0, IDLE, cfg_ready=1, config = DEF_*.

Source files
------------

// File: rtl/breath_pkg.sv
// -----------------------------------------------------------------------------
// breath_pkg
// Shared definitions for the breathing-LED brightness sequencer. The PWM
// datapath and the testbench use the same DEF_* constants.
//   - breath_state_e : sequencer states
//   - DUTY_W_DEF     : default width of duty / step / ceiling
//   - HOLD_W_DEF     : default width of the hold counter (in PWM periods)
//   - DEF_MAX/STEP/HOLD : configuration values loaded on reset
// -----------------------------------------------------------------------------
package breath_pkg;

  localparam int DUTY_W_DEF = 16;
  localparam int HOLD_W_DEF = 8;

  localparam logic [15:0] DEF_MAX  = 16'd50000;
  localparam logic [15:0] DEF_STEP = 16'd25;
  localparam logic [7:0]  DEF_HOLD = 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } breath_state_e;

endpackage

// File: rtl/breath_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// breath_seq_ctrl_if
// Bundles the config handshake, control pulses and PWM-facing outputs of the
// brightness sequencer.
//   master : host / period counter side (drives cfg_*, start, stop, period_end)
//   slave  : sequencer side (drives cfg_ready, duty_cycle, inc_dec_flag,
//            busy, cycle_done)
// -----------------------------------------------------------------------------
interface breath_seq_ctrl_if
  import breath_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [DUTY_W-1:0] cfg_max;
  logic [DUTY_W-1:0] cfg_step;
  logic [HOLD_W-1:0] cfg_hold;
  logic              start;
  logic              stop;
  logic              period_end;
  logic [DUTY_W-1:0] duty_cycle;
  logic              inc_dec_flag;
  logic              busy;
  logic              cycle_done;

  modport master (
    output cfg_valid, cfg_max, cfg_step, cfg_hold, start, stop, period_end,
    input  cfg_ready, duty_cycle, inc_dec_flag, busy, cycle_done
  );

  modport slave (
    input  cfg_valid, cfg_max, cfg_step, cfg_hold, start, stop, period_end,
    output cfg_ready, duty_cycle, inc_dec_flag, busy, cycle_done
  );

endinterface

// File: rtl/breath_step_alu.sv
// -----------------------------------------------------------------------------
// breath_step_alu
// Combinational duty stepper. Rising: duty + step saturating at the ceiling,
// compared in DUTY_W+1 bits so the add can never wrap. Falling: duty - step
// clamped at zero.
//   i_duty, i_step, i_max : current duty, step size, ceiling
//   i_up                  : 1 = rising step, 0 = falling step
//   o_next                : next duty value
//   o_hit_limit           : step reached the ceiling (up) or zero (down)
// -----------------------------------------------------------------------------
module breath_step_alu
  import breath_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic [DUTY_W-1:0] i_duty,
  input  logic [DUTY_W-1:0] i_step,
  input  logic [DUTY_W-1:0] i_max,
  input  logic              i_up,
  output logic [DUTY_W-1:0] o_next,
  output logic              o_hit_limit
);

  logic [DUTY_W:0] w_sum;

  assign w_sum = {1'b0, i_duty} + {1'b0, i_step};

  // Next duty and limit flag for a single rising or falling step
  always_comb begin
    o_next      = '0;
    o_hit_limit = 1'b0;
    if (i_up) begin
      if (w_sum >= {1'b0, i_max}) begin
        o_next      = i_max;
        o_hit_limit = 1'b1;
      end else begin
        o_next      = w_sum[DUTY_W-1:0];
        o_hit_limit = 1'b0;
      end
    end else begin
      if (i_duty <= i_step) begin
        o_next      = '0;
        o_hit_limit = 1'b1;
      end else begin
        o_next      = i_duty - i_step;
        o_hit_limit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/breath_seq_ctrl.sv
// -----------------------------------------------------------------------------
// breath_seq_ctrl
// Brightness sequencer: ramps duty up to a ceiling, holds, ramps down to zero,
// holds, repeats. All duty updates happen on PWM period boundaries.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : cfg_valid/cfg_ready/cfg_max/cfg_step/cfg_hold,
//                      start, stop, period_end in;
//                      duty_cycle, inc_dec_flag, busy, cycle_done out
// -----------------------------------------------------------------------------
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter int                DUTY_W   = DUTY_W_DEF,
  parameter int                HOLD_W   = HOLD_W_DEF,
  parameter logic [DUTY_W-1:0] DEF_MAX  = breath_pkg::DEF_MAX,
  parameter logic [DUTY_W-1:0] DEF_STEP = breath_pkg::DEF_STEP,
  parameter logic [HOLD_W-1:0] DEF_HOLD = breath_pkg::DEF_HOLD
) (
  input logic              sys_clk,
  input logic              sys_rst,
  breath_seq_ctrl_if.slave bus
);

  breath_state_e     r_state;
  logic [DUTY_W-1:0] r_duty;
  logic              r_inc_dec;
  logic              r_cycle_done;
  logic              r_stop_pending;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DUTY_W-1:0] r_cfg_max;
  logic [DUTY_W-1:0] r_cfg_step;
  logic [HOLD_W-1:0] r_cfg_hold;

  logic              w_stop_req;
  logic              w_alu_up;
  logic [DUTY_W-1:0] w_alu_next;
  logic              w_alu_hit;

  // A stop pulse acts in the same cycle it arrives, as well as once latched.
  assign w_stop_req = r_stop_pending | bus.stop;

  // Only RISE (without a stop) and the HOLD_LO exit step upward; every other
  // stepping state steps toward zero.
  assign w_alu_up = (r_state == ST_HOLD_LO) ||
                    ((r_state == ST_RISE) && !w_stop_req);

  breath_step_alu #(.DUTY_W(DUTY_W)) u_alu (
    .i_duty      (r_duty),
    .i_step      (r_cfg_step),
    .i_max       (r_cfg_max),
    .i_up        (w_alu_up),
    .o_next      (w_alu_next),
    .o_hit_limit (w_alu_hit)
  );

  assign bus.cfg_ready    = (r_state == ST_IDLE);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.duty_cycle   = r_duty;
  assign bus.inc_dec_flag = r_inc_dec;
  assign bus.cycle_done   = r_cycle_done;

  // Sequencer FSM, hold counter, config capture and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state        <= ST_IDLE;
      r_duty         <= '0;
      r_inc_dec      <= 1'b0;
      r_cycle_done   <= 1'b0;
      r_stop_pending <= 1'b0;
      r_hold_cnt     <= '0;
      r_cfg_max      <= DEF_MAX;
      r_cfg_step     <= DEF_STEP;
      r_cfg_hold     <= DEF_HOLD;
    end else begin
      r_cycle_done <= 1'b0;

      if (bus.cfg_valid && (r_state == ST_IDLE)) begin
        r_cfg_max  <= bus.cfg_max;
        r_cfg_step <= (bus.cfg_step == '0) ? DUTY_W'(1) : bus.cfg_step;
        r_cfg_hold <= bus.cfg_hold;
      end

      // Latch stop while busy; IDLE entries below clear it again.
      if (r_state != ST_IDLE) begin
        r_stop_pending <= r_stop_pending | bus.stop;
      end

      case (r_state)
        ST_IDLE: begin
          r_duty         <= '0;
          r_inc_dec      <= 1'b0;
          r_stop_pending <= 1'b0;
          if (bus.start && !bus.stop) begin
            r_state <= ST_RISE;
          end
        end

        ST_RISE: begin
          if (bus.period_end) begin
            r_duty <= w_alu_next;
            if (w_stop_req) begin
              r_inc_dec <= 1'b0;
              r_state   <= ST_FALL;
            end else begin
              r_inc_dec <= 1'b1;
              if (w_alu_hit) begin
                r_hold_cnt <= r_cfg_hold;
                r_state    <= ST_HOLD_HI;
              end
            end
          end
        end

        ST_HOLD_HI: begin
          if (bus.period_end) begin
            if (w_stop_req || (r_hold_cnt == '0)) begin
              r_duty    <= w_alu_next;
              r_inc_dec <= 1'b0;
              r_state   <= ST_FALL;
            end else begin
              r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
          end
        end

        ST_FALL: begin
          if (bus.period_end) begin
            r_duty    <= w_alu_next;
            r_inc_dec <= 1'b0;
            if (w_alu_hit) begin
              r_cycle_done <= 1'b1;
              if (w_stop_req) begin
                r_stop_pending <= 1'b0;
                r_state        <= ST_IDLE;
              end else begin
                r_hold_cnt <= r_cfg_hold;
                r_state    <= ST_HOLD_LO;
              end
            end
          end
        end

        ST_HOLD_LO: begin
          if (w_stop_req) begin
            r_stop_pending <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (bus.period_end) begin
            if (r_hold_cnt == '0) begin
              r_duty    <= w_alu_next;
              r_inc_dec <= 1'b1;
              r_state   <= ST_RISE;
            end else begin
              r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_breath_seq_ctrl
// Directed scenarios for the breathing sequencer plus randomized configs
// checked against a period-by-period duty list built from the ramp/hold rules.
// -----------------------------------------------------------------------------
module tb_breath_seq_ctrl;
  import breath_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  int   exp_d[$];
  bit   exp_f[$];
  bit   exp_c[$];

  breath_seq_ctrl_if bus ();

  breath_seq_ctrl dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input int mx, input int st, input int hd);
    bus.cfg_valid = 1'b1;
    bus.cfg_max   = 16'(mx);
    bus.cfg_step  = 16'(st);
    bus.cfg_hold  = 8'(hd);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_pe();
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
  endtask

  // Expected duty per period_end: ramp up to max, 'hold' copies of max,
  // ramp down to 0 (cycle_done on the 0), 'hold' copies of 0, repeat.
  task automatic gen_model(input int mx, input int st, input int hd, input int n);
    int d;
    exp_d.delete();
    exp_f.delete();
    exp_c.delete();
    d = 0;
    while (exp_d.size() < n) begin
      do begin
        d = (d + st >= mx) ? mx : d + st;
        exp_d.push_back(d); exp_f.push_back(1'b1); exp_c.push_back(1'b0);
      end while (d < mx);
      for (int k = 0; k < hd; k++) begin
        exp_d.push_back(mx); exp_f.push_back(1'b1); exp_c.push_back(1'b0);
      end
      do begin
        d = (d <= st) ? 0 : d - st;
        exp_d.push_back(d); exp_f.push_back(1'b0); exp_c.push_back(d == 0);
      end while (d != 0);
      for (int k = 0; k < hd; k++) begin
        exp_d.push_back(0); exp_f.push_back(1'b0); exp_c.push_back(1'b0);
      end
    end
  endtask

  int s1_d[13] = '{30, 60, 90, 100, 100, 100, 70, 40, 10, 0, 0, 0, 30};
  bit s1_f[13] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  bit s1_c[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int s2_d[5]  = '{50, 100, 50, 0, 50};

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_max    = '0;
    bus.cfg_step   = '0;
    bus.cfg_hold   = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.period_end = 1'b0;

    // Reset state
    do_reset();
    chk("rst_duty", bus.duty_cycle, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_flag", bus.inc_dec_flag, 0);
    chk("rst_done", bus.cycle_done, 0);

    // Ramp and hold: max=100 step=30 hold=2, period_end every 10 clocks
    cfg(100, 30, 2);
    do_start();
    chk("s1_busy", bus.busy, 1);
    chk("s1_ready", bus.cfg_ready, 0);
    chk("s1_duty0", bus.duty_cycle, 0);
    for (int i = 0; i < 13; i++) begin
      repeat (9) tick();
      do_pe();
      chk($sformatf("s1_duty[%0d]", i), bus.duty_cycle, s1_d[i]);
      chk($sformatf("s1_flag[%0d]", i), bus.inc_dec_flag, s1_f[i]);
      chk($sformatf("s1_done[%0d]", i), bus.cycle_done, s1_c[i]);
      if (s1_c[i]) begin
        tick();
        chk("s1_done_width", bus.cycle_done, 0);
      end
    end

    // Zero hold: max=100 step=50 hold=0
    do_reset();
    cfg(100, 50, 0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      repeat (3) tick();
      do_pe();
      chk($sformatf("s2_duty[%0d]", i), bus.duty_cycle, s2_d[i]);
    end

    // Config gating while busy, then graceful stop at duty 60 in RISE
    do_reset();
    cfg(100, 30, 2);
    do_start();
    chk("gate_ready", bus.cfg_ready, 0);
    cfg(7, 7, 7);
    do_pe();
    chk("stop_duty30", bus.duty_cycle, 30);
    do_pe();
    chk("stop_duty60", bus.duty_cycle, 60);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_busy_hold", bus.busy, 1);
    repeat (2) tick();
    do_pe();
    chk("stop_fall30", bus.duty_cycle, 30);
    chk("stop_flag", bus.inc_dec_flag, 0);
    do_pe();
    chk("stop_zero", bus.duty_cycle, 0);
    chk("stop_done", bus.cycle_done, 1);
    chk("stop_busy_fall", bus.busy, 0);
    chk("stop_ready", bus.cfg_ready, 1);
    do_pe();
    chk("stop_idle_duty", bus.duty_cycle, 0);
    chk("stop_idle_done", bus.cycle_done, 0);

    // Step of 0 is stored as 1
    do_reset();
    cfg(100, 0, 0);
    do_start();
    for (int i = 1; i <= 3; i++) begin
      do_pe();
      chk($sformatf("step0_duty[%0d]", i), bus.duty_cycle, i);
    end

    // Event races: start+stop stays IDLE; start with period_end not consumed
    do_reset();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("race_ss_busy", bus.busy, 0);
    do_pe();
    chk("race_idle_pe", bus.duty_cycle, 0);
    bus.start      = 1'b1;
    bus.period_end = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.period_end = 1'b0;
    chk("race_sp_busy", bus.busy, 1);
    chk("race_sp_duty", bus.duty_cycle, 0);
    repeat (3) tick();
    chk("race_sp_hold", bus.duty_cycle, 0);
    do_pe();
    chk("race_sp_step", bus.duty_cycle, 32'(DEF_STEP));

    // Reset mid-FALL at duty 40, then defaults in effect
    do_reset();
    cfg(100, 30, 2);
    do_start();
    repeat (8) do_pe();
    chk("mrst_pre40", bus.duty_cycle, 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_duty", bus.duty_cycle, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_ready", bus.cfg_ready, 1);
    chk("mrst_flag", bus.inc_dec_flag, 0);
    do_start();
    do_pe();
    chk("mrst_defstep", bus.duty_cycle, 32'(DEF_STEP));

    // Randomized configs, captured in the same cycle as start
    for (int r = 0; r < 4; r++) begin
      int mx;
      int st;
      int hd;
      mx = int'($urandom_range(3000, 30));
      st = int'($urandom_range(mx / 3, mx / 10 + 1));
      hd = int'($urandom_range(3, 0));
      gen_model(mx, st, hd, 30);
      do_reset();
      bus.cfg_valid = 1'b1;
      bus.cfg_max   = 16'(mx);
      bus.cfg_step  = 16'(st);
      bus.cfg_hold  = 8'(hd);
      bus.start     = 1'b1;
      tick();
      bus.cfg_valid = 1'b0;
      bus.start     = 1'b0;
      for (int i = 0; i < 30; i++) begin
        repeat (int'($urandom_range(3, 0))) tick();
        do_pe();
        chk($sformatf("rnd%0d_duty[%0d]", r, i), bus.duty_cycle, exp_d[i]);
        chk($sformatf("rnd%0d_flag[%0d]", r, i), bus.inc_dec_flag, exp_f[i]);
        chk($sformatf("rnd%0d_done[%0d]", r, i), bus.cycle_done, exp_c[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
